// File: rtl/rggen_register_bus_arbiter_if.sv
// Bundle of host-side request/response signals and the shared register access
// port. The arbiter takes the slave view; hosts and the register block together
// take the master view.
interface rggen_register_bus_arbiter_if #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  // Host side, packed with host 0 at the LSBs
  logic [REQUESTERS-1:0]               i_request;
  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address;
  logic [REQUESTERS-1:0]               i_write;
  logic [REQUESTERS*BUS_WIDTH-1:0]     i_write_data;
  logic [REQUESTERS*STROBE_WIDTH-1:0]  i_strobe;
  logic [REQUESTERS-1:0]               o_ready;
  logic [1:0]                          o_status;
  logic [BUS_WIDTH-1:0]                o_read_data;
  logic [REQUESTERS-1:0]               o_grant;
  logic                                o_busy;

  // Register block side
  logic                                o_access_valid;
  logic [ADDRESS_WIDTH-1:0]            o_access_address;
  logic                                o_access_write;
  logic [BUS_WIDTH-1:0]                o_access_write_data;
  logic [STROBE_WIDTH-1:0]             o_access_strobe;
  logic                                i_access_ready;
  logic [1:0]                          i_access_status;
  logic [BUS_WIDTH-1:0]                i_access_read_data;

  modport slave (
    input  i_request, i_address, i_write, i_write_data, i_strobe,
    input  i_access_ready, i_access_status, i_access_read_data,
    output o_ready, o_status, o_read_data, o_grant, o_busy,
    output o_access_valid, o_access_address, o_access_write,
    output o_access_write_data, o_access_strobe
  );

  modport master (
    output i_request, i_address, i_write, i_write_data, i_strobe,
    output i_access_ready, i_access_status, i_access_read_data,
    input  o_ready, o_status, o_read_data, o_grant, o_busy,
    input  o_access_valid, o_access_address, o_access_write,
    input  o_access_write_data, o_access_strobe
  );
endinterface

// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter sharing one register access port between REQUESTERS
// hosts. One transaction in flight: the winner's fields are latched, driven
// until the register block answers (or the optional timeout expires), and the
// response is returned to the winner as a one-cycle o_ready pulse.
module rggen_register_bus_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input logic                         i_clk,
  input logic                         i_rst,
  rggen_register_bus_arbiter_if.slave bus
);
  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int INDEX_WIDTH  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int COUNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int FIELD_WIDTH  = ADDRESS_WIDTH + 1 + BUS_WIDTH + STROBE_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [REQUESTERS-1:0]     grant_q, grant_d;
  logic [REQUESTERS-1:0]     ready_q, ready_d;
  logic [INDEX_WIDTH-1:0]    last_q, last_d;
  logic [INDEX_WIDTH-1:0]    index_q, index_d;
  logic                      busy_q, busy_d;
  logic                      access_valid_q, access_valid_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic                      write_q, write_d;
  logic [BUS_WIDTH-1:0]      write_data_q, write_data_d;
  logic [STROBE_WIDTH-1:0]   strobe_q, strobe_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [1:0]                status_q, status_d;
  logic [BUS_WIDTH-1:0]      read_data_q, read_data_d;

  // ------------------------------------------------------------------
  // Round-robin selection: hosts above `last` win first; if none of them
  // request, fall back to the lowest requesting host (the wrap-around).
  // ------------------------------------------------------------------
  logic [REQUESTERS-1:0]  upper_mask;
  logic [REQUESTERS-1:0]  upper_request;
  logic [REQUESTERS-1:0]  pick_source;
  logic [REQUESTERS-1:0]  select_onehot;
  logic                   select_valid;
  logic [INDEX_WIDTH-1:0] index_term [REQUESTERS];
  logic [FIELD_WIDTH-1:0] field_term [REQUESTERS];
  logic [INDEX_WIDTH-1:0] select_index;
  logic [FIELD_WIDTH-1:0] select_fields;
  logic                   timeout_hit;

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_host
    logic [FIELD_WIDTH-1:0] host_fields;

    assign upper_mask[gi] = (INDEX_WIDTH'(gi) > last_q);
    assign host_fields    = {
      bus.i_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH],
      bus.i_write[gi],
      bus.i_write_data[gi*BUS_WIDTH +: BUS_WIDTH],
      bus.i_strobe[gi*STROBE_WIDTH +: STROBE_WIDTH]
    };
    // Only the one-hot winner contributes a non-zero term
    assign index_term[gi] = select_onehot[gi] ? INDEX_WIDTH'(gi) : '0;
    assign field_term[gi] = select_onehot[gi] ? host_fields : '0;
  end

  assign upper_request = bus.i_request & upper_mask;
  assign pick_source   = (|upper_request) ? upper_request : bus.i_request;
  // Isolate the lowest set bit of the candidate vector
  assign select_onehot = pick_source & (~pick_source + REQUESTERS'(1));
  assign select_valid  = |bus.i_request;

  // OR-reduce the winner's index and request fields
  always_comb begin
    select_index  = '0;
    select_fields = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      select_index  = select_index | index_term[i];
      select_fields = select_fields | field_term[i];
    end
  end

  // The wait counter only matters when a timeout is configured
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    assign timeout_hit = (count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // Next-state and next-output computation for the IDLE/ACCESS/RESPOND FSM
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    index_d        = index_q;
    busy_d         = busy_q;
    access_valid_d = access_valid_q;
    address_d      = address_q;
    write_d        = write_q;
    write_data_d   = write_data_q;
    strobe_d       = strobe_q;
    count_d        = count_q;
    // Response outputs are non-zero only during the RESPOND cycle
    ready_d        = '0;
    status_d       = '0;
    read_data_d    = '0;

    case (state_q)
      IDLE: begin
        if (select_valid) begin
          state_d        = ACCESS;
          grant_d        = select_onehot;
          index_d        = select_index;
          busy_d         = 1'b1;
          access_valid_d = 1'b1;
          count_d        = '0;
          {address_d, write_d, write_data_d, strobe_d} = select_fields;
        end
      end
      ACCESS: begin
        if (bus.i_access_ready) begin
          // A real answer beats a simultaneous timeout
          state_d        = RESPOND;
          access_valid_d = 1'b0;
          ready_d        = grant_q;
          status_d       = bus.i_access_status;
          read_data_d    = bus.i_access_read_data;
        end else if (timeout_hit) begin
          state_d        = RESPOND;
          access_valid_d = 1'b0;
          ready_d        = grant_q;
          status_d       = 2'b10;
          read_data_d    = '0;
        end else begin
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
        last_d  = index_q;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d        = IDLE;
        grant_d        = '0;
        busy_d         = 1'b0;
        access_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      ready_q        <= '0;
      last_q         <= INDEX_WIDTH'(REQUESTERS - 1);
      index_q        <= '0;
      busy_q         <= 1'b0;
      access_valid_q <= 1'b0;
      address_q      <= '0;
      write_q        <= 1'b0;
      write_data_q   <= '0;
      strobe_q       <= '0;
      count_q        <= '0;
      status_q       <= '0;
      read_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      ready_q        <= ready_d;
      last_q         <= last_d;
      index_q        <= index_d;
      busy_q         <= busy_d;
      access_valid_q <= access_valid_d;
      address_q      <= address_d;
      write_q        <= write_d;
      write_data_q   <= write_data_d;
      strobe_q       <= strobe_d;
      count_q        <= count_d;
      status_q       <= status_d;
      read_data_q    <= read_data_d;
    end
  end

  assign bus.o_ready             = ready_q;
  assign bus.o_status            = status_q;
  assign bus.o_read_data         = read_data_q;
  assign bus.o_grant             = grant_q;
  assign bus.o_busy              = busy_q;
  assign bus.o_access_valid      = access_valid_q;
  assign bus.o_access_address    = address_q;
  assign bus.o_access_write      = write_q;
  assign bus.o_access_write_data = write_data_q;
  assign bus.o_access_strobe     = strobe_q;

endmodule
